// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: FSM state encoding and IR field positions shared by operand_fetch and opfetch_capture
package operand_fetch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RD_A = 2'd1, RD_B = 2'd2, DONE = 2'd3} state_t;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  localparam int C_HI = 18;
  localparam int C_WIDTH = 19;
endpackage

// File: rtl/operand_fetch_capture.sv
// opfetch_capture: WIDTH-bit operand register (clk, clr, load, zero-force, byp selects w_data over d, q out)
module opfetch_capture
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             zero,
  input  logic             byp,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] w_data,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (clr) q <= '0;
    else if (load) q <= zero ? '0 : byp ? w_data : d;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: sequences Rb/Rc reads on a single-port regfile into op_a/op_b (start/ir/imm_sel/ba_sel in; r_addr out, r_data in; wr_en/w_addr/w_data snooped; busy/done out); OPFETCH_BYPASS_EN forwards same-cycle writes
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             imm_sel,
  input  logic             ba_sel,
  output logic [DEPTH-1:0] r_addr,
  input  logic [WIDTH-1:0] r_data,
  input  logic             wr_en,
  input  logic [DEPTH-1:0] w_addr,
  input  logic [WIDTH-1:0] w_data,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done
);
  state_t state;
  logic [3:0] rb, rc;
  logic [C_WIDTH-1:0] c;
  logic imm, ba, hz;
  logic [WIDTH-1:0] ext;
  assign ext = {{(WIDTH-C_WIDTH){c[C_WIDTH-1]}}, c};
  always_ff @(posedge clk)
    if (clr) begin
      state <= IDLE;
      r_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rb <= '0;
      rc <= '0;
      c <= '0;
      imm <= 1'b0;
      ba <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= RD_A;
          busy <= 1'b1;
          r_addr <= DEPTH'(ir[RB_HI:RB_LO]);
          rb <= ir[RB_HI:RB_LO];
          rc <= ir[RC_HI:RC_LO];
          c <= ir[C_HI:0];
          imm <= imm_sel;
          ba <= ba_sel;
        end
        RD_A: begin
          state <= imm ? DONE : RD_B;
          r_addr <= imm ? '0 : DEPTH'(rc);
          done <= imm;
        end
        RD_B: begin
          state <= DONE;
          r_addr <= '0;
          done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
`ifdef OPFETCH_BYPASS_EN
  // the regfile returns the pre-write value when the snooped write hits the address being read
  assign hz = wr_en && w_addr == r_addr;
`else
  logic unused;
  assign hz = 1'b0;
  assign unused = ^{wr_en, w_addr, w_data};
`endif
  opfetch_capture #(.WIDTH(WIDTH)) cap_a (
    .clk(clk), .clr(clr), .load(state == RD_A), .zero(ba && rb == 4'd0), .byp(hz),
    .d(r_data), .w_data(w_data), .q(op_a)
  );
  // immediate loads op_b alongside op_a in RD_A; no regfile read backs it, so no bypass there
  opfetch_capture #(.WIDTH(WIDTH)) cap_b (
    .clk(clk), .clr(clr), .load((state == RD_A && imm) || state == RD_B), .zero(1'b0),
    .byp(hz && state == RD_B), .d(imm ? ext : r_data), .w_data(w_data), .q(op_b)
  );
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: table, hand sequences and randomized fetches checked against a behavioural operand model
module tb_operand_fetch;
  logic clk = 1'b0;
  logic clr, start, imm_sel, ba_sel, wr_en, busy, done;
  logic [31:0] ir, r_data, w_data, op_a, op_b;
  logic [3:0] r_addr, w_addr;
  logic [31:0] rf [16];
  int n_chk = 0;
  int n_pass = 0;
`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic [31:0] ir;
    logic imm, ba;
    logic [31:0] ea, eb;
    int lat;
  } vec_t;
  vec_t tbl [7];
  always #5 clk = ~clk;
  assign r_data = rf[r_addr];
  always @(posedge clk) if (wr_en) rf[w_addr] <= w_data;
  operand_fetch #(.DEPTH(4), .WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .imm_sel(imm_sel), .ba_sel(ba_sel),
    .r_addr(r_addr), .r_data(r_data), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done)
  );
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  function automatic logic [31:0] mk_rr(input logic [3:0] b, input logic [3:0] cc);
    return {9'b0, b, cc, 15'b0};
  endfunction
  function automatic logic [31:0] mk_im(input logic [3:0] b, input logic [18:0] k);
    return {9'b0, b, k};
  endfunction
  function automatic logic [31:0] sext19(input logic [18:0] k);
    int v;
    v = int'(k);
    if (v >= 262144) v = v - 524288;
    return 32'(v);
  endfunction
  // expected operands from the regfile contents before the fetch; hc = cycle of a snooped write (0: none)
  task automatic model(input logic [31:0] i, input logic im, input logic b, input int hc,
                       input logic [3:0] ha, input logic [31:0] hd,
                       output logic [31:0] ea, output logic [31:0] eb, output int elat);
    logic [3:0] rb, rc;
    logic [31:0] vb;
    rb = i[22:19];
    rc = i[18:15];
    ea = (b && rb == 4'd0) ? 32'd0 : (hc == 1 && ha == rb && BYP) ? hd : rf[rb];
    vb = (hc == 1 && ha == rc) ? hd : rf[rc];
    eb = im ? sext19(i[18:0]) : (hc == 2 && ha == rc && BYP) ? hd : vb;
    elat = im ? 2 : 3;
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; w_addr = a; w_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic fetch(input logic [31:0] i, input logic im, input logic b, input int hc,
                       input logic [3:0] ha, input logic [31:0] hd,
                       output int lat, output logic [3:0] a1, output logic [3:0] a2);
    @(negedge clk);
    ir = i; imm_sel = im; ba_sel = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ir = $urandom; imm_sel = 1'($urandom); ba_sel = 1'($urandom);
    lat = 1; a1 = r_addr; a2 = '0;
    while (!done && lat < 8) begin
      if (lat == hc) begin
        wr_en = 1'b1; w_addr = ha; w_data = hd;
      end
      @(negedge clk);
      wr_en = 1'b0;
      lat++;
      if (lat == 2) a2 = r_addr;
    end
  endtask
  initial begin
    int lat, elat, cnt, first, last;
    logic [3:0] a1, a2, ha;
    logic [31:0] ea, eb, i, hd;
    logic im, b, seen;
    int hc;
    clr = 1'b1; start = 1'b0; ir = '0; imm_sel = 1'b0; ba_sel = 1'b0;
    wr_en = 1'b0; w_addr = '0; w_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_r_addr", 32'(r_addr), 32'd0);
    clr = 1'b0;
    for (int k = 0; k < 16; k++)
      wr(4'(k), k == 0 ? 32'hDEAD : k == 2 ? 32'h11 : k == 3 ? 32'h22 : k == 4 ? 32'h1 :
                k == 5 ? 32'h100 : 32'h1000 * k + k);
    tbl[0] = '{mk_rr(2, 3), 1'b0, 1'b0, 32'h11, 32'h22, 3};
    tbl[1] = '{mk_im(5, 19'h7FFFF), 1'b1, 1'b0, 32'h100, 32'hFFFFFFFF, 2};
    tbl[2] = '{mk_rr(0, 3), 1'b0, 1'b1, 32'h0, 32'h22, 3};
    tbl[3] = '{mk_rr(0, 3), 1'b0, 1'b0, 32'hDEAD, 32'h22, 3};
    tbl[4] = '{mk_im(2, 19'h3FFFF), 1'b1, 1'b0, 32'h11, 32'h0003FFFF, 2};
    tbl[5] = '{mk_im(0, 19'h40000), 1'b1, 1'b1, 32'h0, 32'hFFFC0000, 2};
    tbl[6] = '{mk_rr(2, 0), 1'b0, 1'b1, 32'h11, 32'hDEAD, 3};
    for (int k = 0; k < 7; k++) begin
      i = tbl[k].ir;
      fetch(i, tbl[k].imm, tbl[k].ba, 0, 4'd0, 32'd0, lat, a1, a2);
      chk($sformatf("tbl%0d_op_a", k), op_a, tbl[k].ea);
      chk($sformatf("tbl%0d_op_b", k), op_b, tbl[k].eb);
      chk($sformatf("tbl%0d_latency", k), 32'(lat), 32'(tbl[k].lat));
      chk($sformatf("tbl%0d_addr_rb", k), 32'(a1), 32'(i[22:19]));
      if (!tbl[k].imm) chk($sformatf("tbl%0d_addr_rc", k), 32'(a2), 32'(i[18:15]));
      else if (i[18:15] != 4'd0 && i[18:15] != i[22:19])
        chk($sformatf("tbl%0d_imm_no_rc", k), 32'(a2 != i[18:15]), 32'd1);
    end
    fetch(mk_rr(2, 4), 1'b0, 1'b0, 2, 4'd4, 32'h99, lat, a1, a2);
    chk("hz_rdb_op_b", op_b, BYP ? 32'h99 : 32'h1);
    chk("hz_rdb_op_a", op_a, 32'h11);
    fetch(mk_rr(0, 3), 1'b0, 1'b1, 1, 4'd0, 32'h77, lat, a1, a2);
    chk("hz_rda_ba_zero", op_a, 32'h0);
    fetch(mk_rr(6, 3), 1'b0, 1'b0, 1, 4'd6, 32'h55, lat, a1, a2);
    chk("hz_rda_op_a", op_a, BYP ? 32'h55 : 32'h6006);
    @(negedge clk);
    ir = mk_rr(2, 3); imm_sel = 1'b0; ba_sel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_op_a", op_a, 32'd0);
    chk("clr_op_b", op_b, 32'd0);
    chk("clr_r_addr", 32'(r_addr), 32'd0);
    seen = done;
    repeat (5) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("clr_no_done", 32'(seen), 32'd0);
    ir = mk_rr(2, 3); imm_sel = 1'b0; ba_sel = 1'b0; start = 1'b1;
    cnt = 0; first = 0; last = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        if (first == 0) first = k;
        last = k;
      end
    end
    start = 1'b0;
    chk("held_rr_count", 32'(cnt), 32'd3);
    chk("held_rr_first", 32'(first), 32'd3);
    chk("held_rr_last", 32'(last), 32'd11);
    chk("held_rr_op_b", op_b, 32'h22);
    @(negedge clk);
    ir = mk_im(5, 19'h00001); imm_sel = 1'b1; start = 1'b1;
    cnt = 0; first = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
    start = 1'b0;
    chk("held_im_count", 32'(cnt), 32'd3);
    chk("held_im_first", 32'(first), 32'd2);
    for (int k = 0; k < 40; k++) begin
      i = $urandom;
      if ($urandom_range(3) == 0) i[22:19] = 4'd0;
      im = 1'($urandom);
      b = 1'($urandom);
      hc = $urandom_range(2);
      ha = $urandom_range(1) ? ($urandom_range(1) ? i[22:19] : i[18:15]) : 4'($urandom);
      hd = $urandom;
      model(i, im, b, hc, ha, hd, ea, eb, elat);
      fetch(i, im, b, hc, ha, hd, lat, a1, a2);
      chk($sformatf("rnd%0d_op_a", k), op_a, ea);
      chk($sformatf("rnd%0d_op_b", k), op_b, eb);
      chk($sformatf("rnd%0d_latency", k), 32'(lat), 32'(elat));
      chk($sformatf("rnd%0d_addr_rb", k), 32'(a1), 32'(i[22:19]));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
